// File: rtl/llr_buffer_write_if.sv
// Stream-in / RAM-port-A / handoff bundle for llr_buffer_write.
// slave  : the buffer-write block (consumes the LLR stream, drives RAM port A).
// master : the environment (LLR source, RAM, read controller).
interface llr_buffer_write_if #(
  parameter int ADDR_W = 7,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 4
);
  logic [IN_W-1:0]   llr_in;
  logic              llr_valid;
  logic              llr_last;
  logic              llr_ready;
  logic [ADDR_W-1:0] buffer_addr;
  logic [OUT_W-1:0]  rr_data;
  logic              buffer_wr_en;
  logic              flag_org_read_start;
  logic              flag_org_read_end;
  logic              frame_err;

  modport slave (
    input  llr_in, llr_valid, llr_last, flag_org_read_end,
    output llr_ready, buffer_addr, rr_data, buffer_wr_en,
           flag_org_read_start, frame_err
  );

  modport master (
    output llr_in, llr_valid, llr_last, flag_org_read_end,
    input  llr_ready, buffer_addr, rr_data, buffer_wr_en,
           flag_org_read_start, frame_err
  );
endinterface

// File: rtl/llr_buffer_write.sv
// Write-side front end of the LLR original-data store.
// Quantizes a signed LLR stream to OUT_W bits, writes one DEPTH-sample frame
// into RAM port A, pulses flag_org_read_start, then stalls the input until the
// read controller returns flag_org_read_end.
// Optional build macro: LLR_SYM_SAT_EN selects symmetric saturation
// (the most negative OUT_W code is never written).
module llr_buffer_write #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 4,
  parameter int SHIFT  = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  llr_buffer_write_if.slave  bus
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FLUSH = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // Saturation bounds, expressed both at shifted-input width (for comparison)
  // and at output width (for the stored code).
  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(2**(OUT_W-1) - 1);
  localparam logic [OUT_W-1:0]       Q_MAX   = OUT_W'(2**(OUT_W-1) - 1);
`ifdef LLR_SYM_SAT_EN
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(2**(OUT_W-1) - 1));
  localparam logic [OUT_W-1:0]       Q_MIN   = OUT_W'(-(2**(OUT_W-1) - 1));
`else
  localparam logic signed [IN_W-1:0] SAT_MIN = IN_W'(-(2**(OUT_W-1)));
  localparam logic [OUT_W-1:0]       Q_MIN   = OUT_W'(-(2**(OUT_W-1)));
`endif

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               wr_en_q, wr_en_d;
  logic               err_q, err_d;

  logic signed [IN_W-1:0] shifted;
  logic [OUT_W-1:0]       quant;
  logic                   accept;

  // Handshake outputs come straight from the state register.
  assign bus.llr_ready           = (state_q == S_FILL);
  assign bus.flag_org_read_start = (state_q == S_START);
  assign bus.buffer_addr         = addr_q;
  assign bus.rr_data             = data_q;
  assign bus.buffer_wr_en        = wr_en_q;
  assign bus.frame_err           = err_q;

  assign accept = bus.llr_valid & (state_q == S_FILL);

  // Arithmetic shift (floor) followed by saturation to the output range.
  always_comb begin
    shifted = $signed(bus.llr_in) >>> SHIFT;
    if (shifted > SAT_MAX) begin
      quant = Q_MAX;
    end else if (shifted < SAT_MIN) begin
      quant = Q_MIN;
    end else begin
      quant = shifted[OUT_W-1:0];
    end
  end

  // Next-state, sample counter and registered write-port/error decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          data_d  = quant;
          if (cnt_q == CNT_LAST) begin
            // Frame length is fixed; a missing last marker is only flagged.
            err_d   = ~bus.llr_last;
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else begin
            // An early last marker is flagged but does not close the frame.
            err_d = bus.llr_last;
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_FLUSH: state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.flag_org_read_end) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_llr_buffer_write.sv
// Self-checking bench for llr_buffer_write (default build; LLR_SYM_SAT_EN
// switches the expected negative saturation code).
module tb_llr_buffer_write;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int IN_W   = 8;
  localparam int OUT_W  = 4;
  localparam int SHIFT  = 2;

  logic sys_clk;
  logic sys_rst;

  llr_buffer_write_if #(.ADDR_W(ADDR_W), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  llr_buffer_write #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as timestamps and a frame position.
  int cyc     = 0;
  int t_last  = -100;  // cycle of the most recent frame-closing accept
  int pos     = 0;     // address the next accepted sample goes to
  bit blocked = 1'b0;  // frame handed off, waiting for read end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Quantizer reference: floor division by 2^SHIFT, clamp to output range.
  function automatic logic [3:0] qref(input logic [7:0] x);
    int v, f, lo, hi, d;
    d  = 1 << SHIFT;
    hi = (1 << (OUT_W - 1)) - 1;
`ifdef LLR_SYM_SAT_EN
    lo = -hi;
`else
    lo = -hi - 1;
`endif
    v = int'(x);
    if (v > 127) v = v - 256;
    f = (v >= 0) ? (v / d) : -((-v + d - 1) / d);
    if (f > hi) f = hi;
    if (f < lo) f = lo;
    return f[3:0];
  endfunction

  // One clock cycle: drive at negedge, check ready, then check the
  // registered outputs produced by that cycle's inputs.
  task automatic step(input bit v, input logic [7:0] x, input bit l, input bit re);
    bit         acc, e_wr, e_err;
    int         e_addr;
    logic [3:0] e_data;
    @(negedge sys_clk);
    bus.llr_valid         = v;
    bus.llr_in            = x;
    bus.llr_last          = l;
    bus.flag_org_read_end = re;
    chk("llr_ready", {31'd0, bus.llr_ready}, {31'd0, !blocked});
    acc    = v && !blocked;
    e_wr   = acc;
    e_err  = 1'b0;
    e_addr = pos;
    e_data = qref(x);
    if (acc) begin
      e_err = (l != (pos == DEPTH - 1));
      if (pos == DEPTH - 1) begin
        pos     = 0;
        blocked = 1'b1;
        t_last  = cyc;
      end else begin
        pos++;
      end
    end else if (blocked && re && cyc >= t_last + 3) begin
      blocked = 1'b0;
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    chk("buffer_wr_en", {31'd0, bus.buffer_wr_en}, {31'd0, e_wr});
    if (e_wr) begin
      chk("buffer_addr", {25'd0, bus.buffer_addr}, e_addr);
      chk("rr_data", {28'd0, bus.rr_data}, {28'd0, e_data});
      $display("WR addr=%0d in=%0d data=%h err=%0b", bus.buffer_addr, $signed(x),
               bus.rr_data, bus.frame_err);
    end
    chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e_err});
    chk("read_start", {31'd0, bus.flag_org_read_start}, {31'd0, (cyc == t_last + 2)});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, bus.llr_ready}, 32'd1);
    chk({tag, "_addr"},  {25'd0, bus.buffer_addr}, 32'd0);
    chk({tag, "_data"},  {28'd0, bus.rr_data}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, bus.buffer_wr_en}, 32'd0);
    chk({tag, "_start"}, {31'd0, bus.flag_org_read_start}, 32'd0);
    chk({tag, "_err"},   {31'd0, bus.frame_err}, 32'd0);
  endtask

  // Asserted mid-cycle, shortly after the preceding step's check point.
  task automatic async_reset();
    #2;
    sys_rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    bus.llr_valid         = 1'b0;
    bus.llr_last          = 1'b0;
    bus.flag_org_read_end = 1'b0;
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    pos     = 0;
    blocked = 1'b0;
    t_last  = -100;
    $display("RESET mid-cycle applied and released");
  endtask

  initial begin
    logic [7:0] x;
    sys_rst               = 1'b1;
    bus.llr_in            = '0;
    bus.llr_valid         = 1'b0;
    bus.llr_last          = 1'b0;
    bus.flag_org_read_end = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk_reset_vals("por");
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // Frame 1: ramp 4*i, correct last marker.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(4 * i), (i == DEPTH - 1), 1'b0);
      if (i == 1) chk("sample1_data", {28'd0, bus.rr_data}, 32'd1);
    end
    $display("FRAME 1 written");

    // Backpressure; read end during FLUSH/START must be ignored.
    for (int k = 0; k < 20; k++) step(1'b1, 8'h55, 1'b0, (k < 2));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    $display("FRAME 1 released by read end");

    // Frame 2: extremes, random data with bubbles, early last and missing last.
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'($urandom), 1'b0);
      if (i == 0)      x = 8'd127;
      else if (i == 1) x = 8'h80;
      else if (i == 2) x = 8'hFD;
      else             x = 8'($urandom);
      step(1'b1, x, (i == 50), 1'b0);
      if (i == 0) chk("q_pos127", {28'd0, bus.rr_data}, 32'h7);
`ifdef LLR_SYM_SAT_EN
      if (i == 1) chk("q_neg128", {28'd0, bus.rr_data}, 32'h9);
`else
      if (i == 1) chk("q_neg128", {28'd0, bus.rr_data}, 32'h8);
`endif
      if (i == 2) chk("q_neg3", {28'd0, bus.rr_data}, 32'hF);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    $display("FRAME 2 written and released");

    // Frame 3: reset after 60 samples, no start pulse expected.
    for (int i = 0; i < 60; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    async_reset();
    chk("ready_after_rst", {31'd0, bus.llr_ready}, 32'd1);

    // Frame 4: full random frame after reset, starts at address 0.
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(0, 5) == 0) step(1'b0, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'($urandom), (i == DEPTH - 1), 1'b0);
    end
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 8'hF0, 1'b0, 1'b0);
    $display("FRAME 4 written, next frame started");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
